// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner: synchronise, debounce and pulse-shape two push-buttons into mutually exclusive level-change requests
module btn_pulse_channel #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter logic [31:0] REPEAT_DELAY    = 32'd50_000_000,
  parameter logic [31:0] REPEAT_PERIOD   = 32'd25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic req
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t state, state_n;
  logic s1, s, d;
  logic [31:0] dcnt, rcnt, rcnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s <= 1'b0;
      d <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= raw;
      s <= s1;
      if (s == d) dcnt <= '0;
      else if (dcnt == DEBOUNCE_CYCLES - 32'd1) begin
        d <= s;
        dcnt <= '0;
      end else dcnt <= dcnt + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt <= '0;
    end else begin
      state <= state_n;
      rcnt <= rcnt_n;
    end
  end
  // release wins over any repeat tick landing in the same cycle
  always_comb begin
    state_n = state;
    rcnt_n = rcnt;
    req = 1'b0;
    if (!d) begin
      state_n = IDLE;
      rcnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          req = 1'b1;
          state_n = DELAY;
          rcnt_n = '0;
        end
        DELAY:
          if (rcnt == REPEAT_DELAY - 32'd1) begin
            if (REPEAT_EN) begin
              req = 1'b1;
              rcnt_n = '0;
              state_n = REPEAT;
            end
          end else rcnt_n = rcnt + 32'd1;
        REPEAT:
          if (rcnt == REPEAT_PERIOD - 32'd1) begin
            req = 1'b1;
            rcnt_n = '0;
          end else rcnt_n = rcnt + 32'd1;
        default: state_n = IDLE;
      endcase
    end
  end
  assign held = d;
endmodule

module btn_pulse_conditioner #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter logic [31:0] REPEAT_DELAY    = 32'd50_000_000,
  parameter logic [31:0] REPEAT_PERIOD   = 32'd25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_faster_raw,
  input  logic btn_slower_raw,
  output logic btn_faster,
  output logic btn_slower,
  output logic faster_held,
  output logic slower_held
);
  logic req_f, req_s;
  btn_pulse_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_faster (.clk(clk), .rst(rst), .raw(btn_faster_raw), .held(faster_held), .req(req_f));
  btn_pulse_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_slower (.clk(clk), .rst(rst), .raw(btn_slower_raw), .held(slower_held), .req(req_s));
  // a colliding slower request is dropped, never queued
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_faster <= 1'b0;
      btn_slower <= 1'b0;
    end else begin
      btn_faster <= req_f;
      btn_slower <= req_s & ~req_f;
    end
  end
endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// tb_btn_pulse_conditioner: directed and random stimulus against a history-based reference model
module tb_btn_pulse_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_faster_raw = 1'b0;
  logic btn_slower_raw = 1'b0;
  logic btn_faster, btn_slower, faster_held, slower_held;
  logic btn_faster1, btn_slower1, faster_held1, slower_held1;
  int total = 0;
  int bad = 0;
  int cnt_f, cnt_s, cnt_f1;
  bit s1 [2];
  bit s2 [2];
  bit d [2];
  bit hist [2][DB];
  int k [2];
  bit ef0, es0, ef1, es1;

  always #5 clk = ~clk;

  btn_pulse_conditioner #(
    .DEBOUNCE_CYCLES(32'd4), .REPEAT_EN(1'b1), .REPEAT_DELAY(32'd10), .REPEAT_PERIOD(32'd5)
  ) dut (
    .clk(clk), .rst(rst), .btn_faster_raw(btn_faster_raw), .btn_slower_raw(btn_slower_raw),
    .btn_faster(btn_faster), .btn_slower(btn_slower), .faster_held(faster_held), .slower_held(slower_held)
  );

  btn_pulse_conditioner #(
    .DEBOUNCE_CYCLES(32'd4), .REPEAT_EN(1'b0), .REPEAT_DELAY(32'd10), .REPEAT_PERIOD(32'd5)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_faster_raw(btn_faster_raw), .btn_slower_raw(btn_slower_raw),
    .btn_faster(btn_faster1), .btn_slower(btn_slower1), .faster_held(faster_held1), .slower_held(slower_held1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_counts();
    cnt_f = 0;
    cnt_s = 0;
    cnt_f1 = 0;
  endtask

  // d flips once the last DB synchronised samples all disagree with it;
  // pulses fire at hold age 0, then RD, RD+RP, ... cycles after the rise
  task automatic step(input bit r, input bit f, input bit sl);
    bit raw [2];
    bit p [2];
    bit q [2];
    bit diff, dn;
    rst = r;
    btn_faster_raw = f;
    btn_slower_raw = sl;
    raw[0] = f;
    raw[1] = sl;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        s1[i] = 0; s2[i] = 0; d[i] = 0; k[i] = 0;
        for (int j = 0; j < DB; j++) hist[i][j] = 0;
      end
      {ef0, es0, ef1, es1} = 4'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        p[i] = d[i] && (k[i] == 0 || (k[i] >= RD && (k[i] - RD) % RP == 0));
        q[i] = d[i] && k[i] == 0;
        for (int j = DB - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = s2[i];
        diff = 1;
        for (int j = 0; j < DB; j++) diff &= (hist[i][j] != d[i]);
        dn = diff ? !d[i] : d[i];
        k[i] = (dn && !d[i]) ? 0 : k[i] + 1;
        d[i] = dn;
        s2[i] = s1[i];
        s1[i] = raw[i];
      end
      ef0 = p[0];
      es0 = p[1] & !p[0];
      ef1 = q[0];
      es1 = q[1] & !q[0];
    end
    #1;
    chk("btn_faster", btn_faster, ef0);
    chk("btn_slower", btn_slower, es0);
    chk("faster_held", faster_held, d[0]);
    chk("slower_held", slower_held, d[1]);
    chk("norep_btn_faster", btn_faster1, ef1);
    chk("norep_btn_slower", btn_slower1, es1);
    chk("norep_faster_held", faster_held1, d[0]);
    chk("norep_slower_held", slower_held1, d[1]);
    chk("exclusive", btn_faster & btn_slower, 0);
    cnt_f += int'(btn_faster);
    cnt_s += int'(btn_slower);
    cnt_f1 += int'(btn_faster1);
  endtask

  initial begin
    bit rf, rs;
    bit bounce [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    repeat (3) step(1, 1, 1);
    clr_counts();
    repeat (8) step(0, 1, 1);
    chk("reset_release_faster_pulses", cnt_f, 1);
    chk("reset_release_slower_pulses", cnt_s, 0);
    repeat (12) step(0, 0, 0);

    clr_counts();
    foreach (bounce[i]) step(0, bounce[i], 0);
    repeat (12) step(0, 1, 0);
    chk("bounce_pulses", cnt_f, 1);
    repeat (12) step(0, 0, 0);

    clr_counts();
    repeat (40) step(0, 0, 1);
    repeat (12) step(0, 0, 0);
    chk("repeat_slower_pulses", cnt_s, 7);
    chk("repeat_faster_pulses", cnt_f, 0);

    clr_counts();
    repeat (100) step(0, 1, 0);
    repeat (12) step(0, 0, 0);
    chk("norep_pulses", cnt_f1, 1);

    clr_counts();
    repeat (30) step(0, 1, 1);
    repeat (12) step(0, 0, 0);
    chk("simul_faster_pulses", cnt_f, 5);
    chk("simul_slower_pulses", cnt_s, 0);

    rf = 0;
    rs = 0;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(7) == 0) rf = !rf;
      if ($urandom_range(7) == 0) rs = !rs;
      step($urandom_range(199) == 0, rf, rs);
    end

    repeat (2) step(1, 0, 0);
    repeat (19) step(0, 1, 0);
    step(1, 1, 0);
    clr_counts();
    repeat (12) step(0, 1, 0);
    chk("reset_mid_repeat_pulses", cnt_f, 1);
    repeat (12) step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_pulse_conditioner.md
Name: btn_pulse_conditioner

Overview:
- Upstream stage of the clock speed switcher.
- Takes the two raw, asynchronous, bouncing board push-buttons (faster/slower) and synchronises and debounces them on the fast system clock.
- Emits clean single-cycle pulses for the switcher's level-change inputs, with optional auto-repeat while a button is held.
- Guarantees the switcher never sees bounce glitches or two simultaneous requests.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz); legal range 1..2^32-1.
- REPEAT_EN, 1, 1 = auto-repeat while held; 0 = one pulse per press.
- REPEAT_DELAY, 50_000_000, cycles from the initial pulse to the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 25_000_000, cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk  input  1  fastest system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_faster_raw  input  1  raw asynchronous faster button, active-high.
- btn_slower_raw  input  1  raw asynchronous slower button, active-high.
- btn_faster  output  1  registered single-cycle pulse; a request to go one level faster.
- btn_slower  output  1  registered single-cycle pulse; a request to go one level slower.
- faster_held  output  1  debounced level of the faster button.
- slower_held  output  1  debounced level of the slower button.

Behaviour:
- Reset (rst=1 at a posedge):
  - Synchroniser flops, debounced levels, counters and both outputs clear to 0.
  - Both channel FSMs go to IDLE.
  - Reset overrides everything in the same cycle; reset mid-press aborts any pending debounce or repeat.
- Synchroniser: two-flop chain per channel; the second flop is s. There is no combinational path from a raw input to any output.
- Debounce, per channel (32-bit counter dcnt, debounced level d):
  - If s == d: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: d <= s and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any bounce back to d before qualification restarts the count from 0.
  - Latency from a clean raw edge to d changing: 2 + DEBOUNCE_CYCLES cycles.
- faster_held / slower_held drive d directly.
- Pulse FSM, per channel (32-bit counter rcnt):
  - IDLE: on the cycle d rises, raise pulse request p, rcnt <= 0, go to DELAY.
  - DELAY: while d=1, rcnt increments. At rcnt == REPEAT_DELAY-1, if REPEAT_EN=1: p, rcnt <= 0, go to REPEAT. With REPEAT_EN=0, stay in DELAY with rcnt saturated; no further pulses.
  - REPEAT: while d=1, rcnt increments. At rcnt == REPEAT_PERIOD-1: p, rcnt <= 0.
  - In any state, d=0 means go to IDLE with rcnt <= 0 and no pulse. Release has priority over a coinciding repeat tick.
- Pulse timing:
  - The initial output pulse is high for exactly one cycle, one cycle after d rises.
  - Repeat pulses follow at +REPEAT_DELAY, then every +REPEAT_PERIOD, cycles after the initial pulse.
- Arbitration, applied to p_faster and p_slower before the output register:
  - If both request in the same cycle, btn_faster is emitted and the slower request is dropped, not deferred.
  - At most one output is high in any cycle.
  - Both FSMs keep running independently; arbitration affects outputs only.
- Button held through reset release: after reset, s=1 differs from d=0, so the press qualifies normally. One initial pulse is emitted at 2+DEBOUNCE_CYCLES+1 cycles after reset deasserts.
- Counter wrap: counters never wrap; they clear at their terminal values and saturate in DELAY when REPEAT_EN=0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5 unless stated.
1. Reset: assert rst for 3 cycles with both raw inputs at 1 and observe the outputs during reset, then drop rst. All outputs are 0 during reset; the first btn_faster pulse appears 7 cycles after rst deasserts and is exactly 1 cycle wide.
2. Bounce rejection: btn_faster_raw toggles 1,0,1,0 with 2-cycle widths, then holds 1. faster_held rises only 4 stable cycles after the final rising edge is synchronised; exactly one initial btn_faster pulse.
3. Auto-repeat: hold btn_slower_raw for 40 cycles after qualification. btn_slower pulses at t0, t0+10, t0+15, t0+20, t0+25, t0+30, t0+35 (7 pulses); after release, faster_held/slower_held drop 4 cycles post-sync and no further pulses occur.
4. REPEAT_EN=0: hold btn_faster_raw for 100 cycles. Exactly one btn_faster pulse; faster_held stays 1 until release is debounced.
5. Simultaneous press: raise both raw inputs on the same edge. btn_faster pulses at t0 and btn_slower stays 0 at t0. At t0+10, repeats collide again: only btn_faster is high. Across 1000 random cycles, both outputs are never high together.
6. Reset mid-repeat: assert rst in the cycle where rcnt==3 in REPEAT state, then release with the button still held. There is no stale repeat pulse; the sequence restarts with an initial pulse 7 cycles after reset deasserts.
